// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, with a 4-mode immediate extractor.
// Define IR_SCAN_EN to add a serial scan chain through Ir (ports Test, SDI, SDO).
module ir_prefetch_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           IrIn,
    input  logic                       IrInValid,
    output logic                       IrInReady,
    input  logic                       Advance,
    input  logic                       Flush,
    input  logic [1:0]                 ImmSel,
    output logic [WIDTH-1:0]           Ir,
    output logic                       IrValid,
    output logic [WIDTH-1:0]           Imm,
    output logic [$clog2(DEPTH+1)-1:0] Count
`ifdef IR_SCAN_EN
    ,
    input  logic                       Test,
    input  logic                       SDI,
    output logic                       SDO
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ir;
    logic             ir_valid;
    logic [WIDTH-1:0] imm;
    logic             scan;
    logic             ready, accept, load, pop, bypass, push;

`ifdef IR_SCAN_EN
    assign scan = Test;
    assign SDO  = ir[WIDTH-1];
`else
    assign scan = 1'b0;
`endif

    // Ready never looks at IrInValid, so the fetch side sees no combinational loop.
    assign ready  = !Reset && !Flush && !scan && (count < FULL);
    assign accept = IrInValid && ready;
    assign load   = !ir_valid || Advance;
    assign pop    = load && (count != '0);
    assign bypass = load && (count == '0) && accept;
    assign push   = accept && !bypass;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= IrIn;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir       <= '0;
            ir_valid <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end
`ifdef IR_SCAN_EN
        else if (Test) begin
            ir <= {ir[WIDTH-2:0], SDI};
        end
`endif
        else if (Flush) begin
            // Ir keeps its stale value; only its valid flag drops.
            ir_valid <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (pop) begin
                ir       <= mem[rd_ptr];
                ir_valid <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (bypass) begin
                ir       <= IrIn;
                ir_valid <= 1'b1;
            end else if (load) begin
                ir_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        imm = '0;
        case (ImmSel)
            2'b00: imm = {{(WIDTH-8){ir[7]}}, ir[7:0]};
            2'b01: imm = {{(WIDTH-5){ir[4]}}, ir[4:0]};
            2'b10: imm = {{(WIDTH-8){1'b0}}, ir[7:0]};
            default: begin
                imm[15:8] = ir[7:0];
                for (int i = 16; i < WIDTH; i++) begin
                    imm[i] = ir[7];
                end
            end
        endcase
    end

    assign IrInReady = ready;
    assign Ir        = ir;
    assign IrValid   = ir_valid;
    assign Imm       = imm;
    assign Count     = count;
endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised successor to the single-word instruction register.
- Adds a DEPTH-entry prefetch FIFO ahead of the instruction register (Ir), with a valid/ready fetch handshake, decode-side Advance and Flush controls, and a 4-mode immediate extractor.
- Sits between the memory fetch path and the decoder/ALU immediate mux.

Parameters:
WIDTH, 16, instruction/immediate width in bits; legal range 16..32.
DEPTH, 4, prefetch FIFO entries excluding Ir; power of two, 2..16.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous reset, active-high.
IrIn  input  WIDTH  fetched instruction word.
IrInValid  input  1  IrIn holds a valid word.
IrInReady  output  1  block accepts IrIn this cycle.
Advance  input  1  decoder has consumed Ir; load next word.
Flush  input  1  discard all queued and current instructions (branch taken).
ImmSel  input  2  immediate mode select.
Ir  output  WIDTH  current instruction register.
IrValid  output  1  Ir holds a live instruction.
Imm  output  WIDTH  immediate extracted from Ir (combinational).
Count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding Ir.

Behaviour:
- Reset (synchronous, sampled on Clock rise) has priority over everything:
  - Ir=0, IrValid=0, Count=0, FIFO pointers=0.
  - Imm=0 in every ImmSel mode, since Imm derives from Ir=0.
- IrInReady = !Reset && !Flush && (Count < DEPTH). Combinational from registers and these two inputs only; never from IrInValid.
- Accept = IrInValid && IrInReady.
- Load = !IrValid || Advance. Advance while IrValid=0 is harmless and is not an error.
- Per cycle when not Reset/Flush, in priority order:
  - Load && Count>0: Ir<=FIFO head, pop, IrValid<=1. If Accept, IrIn is pushed in the same cycle, so Count is unchanged.
  - Load && Count==0 && Accept: bypass. Ir<=IrIn, IrValid<=1, nothing enqueued. Latency from IrIn to Ir is 1 cycle.
  - Load && Count==0 && !Accept: IrValid<=0. Ir holds its last value.
  - !Load && Accept: push, Count+1.
- Pointers wrap modulo DEPTH.
- Full (Count==DEPTH): IrInReady=0. A pop in that cycle reopens IrInReady the next cycle. The one-cycle bubble is accepted behaviour.
- Flush:
  - Count<=0, pointers<=0, IrValid<=0. Ir value is retained.
  - IrInReady=0 during Flush, so no word is lost mid-handshake.
  - Flush with Advance: Flush wins.
- Word order out of Ir equals acceptance order. No duplication or loss across bypass/FIFO transitions.
- Imm (combinational on Ir, independent of IrValid):
  - 00 long: sign-extend Ir[7:0].
  - 01 short: sign-extend Ir[4:0].
  - 10 unsigned: zero-extend Ir[7:0].
  - 11 high: Ir[7:0] placed at bits [15:8], zeros elsewhere. For WIDTH>16, bits above 15 are sign-extended from Ir[7].
- Reset asserted mid-stream: all state cleared on that edge. Queued words are discarded.

Optional Feature:
IR_SCAN_EN
- Defined:
  - Adds ports Test (in, 1), SDI (in, 1), SDO (out, 1).
  - While Test=1 and Reset=0: Ir shifts each cycle as Ir<={Ir[WIDTH-2:0],SDI}.
  - SDO=Ir[WIDTH-1] at all times.
  - FIFO, Count and IrValid are frozen; IrInReady=0; Advance and Flush are ignored.
  - Reset still overrides Test.
- Not defined:
  - Ports absent, no scan logic; behaviour as above.

Test Plan:
- Reset, then hold IrInValid=0 for 2 cycles -> Ir=0, IrValid=0, Count=0, Imm=0 for ImmSel 00..11, IrInReady=1.
- Bypass: empty queue, single IrIn=16'hFFFF valid with Advance=0 -> after 1 cycle Ir=FFFF, IrValid=1, Count=0. Then IrIn=16'h001F valid with Advance=0 -> Count=1, Ir still FFFF.
- Fill to full, DEPTH=4: push 1,2,3,4,5 with Advance=0 and IrValid=1 -> Count=4, IrInReady=0, 5th word not accepted. Assert Advance for 5 cycles -> Ir sequence 1..4 then 5 once resent. Finally IrValid=0.
- Simultaneous pop/push at Count=2 -> Count stays 2, order preserved.
- Immediates with Ir=16'h00EF -> ImmSel 01 gives 000F; 00 gives FFEF; 10 gives 00EF; 11 gives EF00. With Ir=16'hFFFF, ImmSel 01 gives FFFF.
- Flush with Count=3 and IrInValid=1 -> IrInReady=0 that cycle, next cycle Count=0, IrValid=0. The next valid word bypasses into Ir. Under IR_SCAN_EN, Test=1 and SDI pattern 1010... for 16 cycles -> Ir=AAAA, Count unchanged.
